// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, constants and store masking for param_register_file
package regfile_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

  // Upper bounds used by the shared masking helper
  localparam int RF_MAX_W     = 64;
  localparam int RF_MAX_REGS  = 256;
  localparam int RF_IDX_MAX_W = 8;

  // Registers 3, 4 and 5 hold full data width by default
  localparam logic [RF_MAX_REGS-1:0] RF_DEFAULT_WIDE_MASK = RF_MAX_REGS'(16'h0038);

  // Value a register will actually hold: wide registers keep everything,
  // narrow ones keep the low narrow_w bits, zero-extended.
  function automatic logic [RF_MAX_W-1:0] rf_store_mask(
    input logic [RF_MAX_REGS-1:0]  wide_mask,
    input int unsigned             narrow_w,
    input logic [RF_IDX_MAX_W-1:0] idx,
    input logic [RF_MAX_W-1:0]     data
  );
    logic [RF_MAX_W-1:0] keep;
    if (wide_mask[idx] || narrow_w >= RF_MAX_W) begin
      return data;
    end
    keep = (RF_MAX_W'(1) << narrow_w) - RF_MAX_W'(1);
    return data & keep;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// rtl/regfile_clear_fsm.sv - sequential zeroing sweep over registers 1..NUM_REGS-1
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  output logic             busy,
  output logic             sweep_we,
  output logic [IDX_W-1:0] sweep_index
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  rf_state_t        state, state_next;
  logic [IDX_W-1:0] ptr, ptr_next;

  // State and pointer register; reset always launches a fresh sweep
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RF_CLEAR;
      ptr   <= IDX_W'(1);
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // Next state: a clear request restarts, otherwise walk to the last index
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    if (clear) begin
      state_next = RF_CLEAR;
      ptr_next   = IDX_W'(1);
    end else if (state == RF_CLEAR) begin
      if (ptr == LAST_IDX) begin
        state_next = RF_IDLE;
      end else begin
        ptr_next = ptr + IDX_W'(1);
      end
    end
  end

  // Outputs: every CLEAR cycle zeroes the register at ptr
  always_comb begin
    busy        = (state == RF_CLEAR);
    sweep_we    = (state == RF_CLEAR);
    sweep_index = ptr;
  end

endmodule

// File: rtl/param_register_file.sv
// rtl/param_register_file.sv - 2R1W register file with bypass, clear sweep and drop flag
module param_register_file
  import regfile_pkg::*;
#(
  parameter int                     DATA_W    = 19,
  parameter int                     NARROW_W  = 16,
  parameter int                     NUM_REGS  = 16,
  localparam int                    IDX_W     = $clog2(NUM_REGS),
  parameter logic [RF_MAX_REGS-1:0] WIDE_MASK = RF_DEFAULT_WIDE_MASK,
  parameter int                     BYPASS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              we,
  input  logic [IDX_W-1:0]  write_index,
  input  logic [DATA_W-1:0] write_data,
  input  logic [IDX_W-1:0]  read_index_1,
  input  logic [IDX_W-1:0]  read_index_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic              busy,
  output logic              write_dropped
);

  localparam logic [IDX_W:0] NUM_REGS_EXT = (IDX_W + 1)'(NUM_REGS);

  logic              sweep_we;
  logic [IDX_W-1:0]  sweep_index;
  logic              write_legal;
  logic              user_accept;
  logic [RF_MAX_W-1:0] user_masked_full;
  logic [DATA_W-1:0] user_masked;
  logic              unused_mask_bits;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_index;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_word [NUM_REGS];

  regfile_clear_fsm #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_clear_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .busy        (busy),
    .sweep_we    (sweep_we),
    .sweep_index (sweep_index)
  );

  // User write qualification and the value storage would hold for it
  always_comb begin
    write_legal      = ({1'b0, write_index} < NUM_REGS_EXT) && (write_index != '0);
    user_accept      = we && !busy && write_legal;
    user_masked_full = rf_store_mask(WIDE_MASK, NARROW_W, RF_IDX_MAX_W'(write_index),
                                     RF_MAX_W'(write_data));
    user_masked      = user_masked_full[DATA_W-1:0];
    unused_mask_bits = |user_masked_full;
  end

  // Sweep owns the write port while busy; user writes are accepted only when idle
  always_comb begin
    wr_en    = sweep_we || user_accept;
    wr_index = sweep_we ? sweep_index : write_index;
    wr_data  = sweep_we ? '0 : user_masked;
  end

  assign rd_word[0] = '0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
    localparam int W = WIDE_MASK[g] ? DATA_W : NARROW_W;
    logic [W-1:0] q;
    // Per-register storage sized to its architectural width, no reset
    always_ff @(posedge clk) begin
      if (wr_en && (wr_index == IDX_W'(g))) begin
        q <= wr_data[W-1:0];
      end
    end
    assign rd_word[g] = DATA_W'(q);
  end

  // Read port 1: zero while sweeping, then bypass, then storage
  always_comb begin
    read_data_1 = '0;
    if (!busy) begin
      if ((BYPASS != 0) && user_accept && (write_index == read_index_1)) begin
        read_data_1 = user_masked;
      end else if ({1'b0, read_index_1} < NUM_REGS_EXT) begin
        read_data_1 = rd_word[read_index_1];
      end
    end
  end

  // Read port 2: same selection as port 1
  always_comb begin
    read_data_2 = '0;
    if (!busy) begin
      if ((BYPASS != 0) && user_accept && (write_index == read_index_2)) begin
        read_data_2 = user_masked;
      end else if ({1'b0, read_index_2} < NUM_REGS_EXT) begin
        read_data_2 = rd_word[read_index_2];
      end
    end
  end

  // Flag a legal write that arrived while the sweep held the array
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write_dropped <= 1'b0;
    end else begin
      write_dropped <= we && busy && write_legal;
    end
  end

endmodule

// File: tb/tb_param_register_file.sv
// tb/tb_param_register_file.sv - self-checking bench for param_register_file
module tb_param_register_file;

  logic        clk = 1'b0;
  logic        rst_n, clear, we;
  logic [3:0]  wi, ri1, ri2;
  logic [18:0] wd;
  logic [18:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic        a_busy, b_busy, a_drop, b_drop;

  int total = 0;
  int bad   = 0;

  logic [18:0] mem [16];
  int          sweep_left;
  logic        drop_exp;

  always #5 clk = ~clk;

  param_register_file #(.BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .we(we),
    .write_index(wi), .write_data(wd),
    .read_index_1(ri1), .read_index_2(ri2),
    .read_data_1(a_rd1), .read_data_2(a_rd2),
    .busy(a_busy), .write_dropped(a_drop)
  );

  param_register_file #(.BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .we(we),
    .write_index(wi), .write_data(wd),
    .read_index_1(ri1), .read_index_2(ri2),
    .read_data_1(b_rd1), .read_data_2(b_rd2),
    .busy(b_busy), .write_dropped(b_drop)
  );

  function automatic logic [18:0] mask_model(input int idx, input logic [18:0] d);
    return (idx >= 3 && idx <= 5) ? d : {3'b000, d[15:0]};
  endfunction

  function automatic logic [18:0] exp_rd(input int ri, input bit byp);
    if (sweep_left > 0) return 19'h0;
    if (byp && we && wi != 0 && int'(wi) == ri) return mask_model(int'(wi), wd);
    return mem[ri];
  endfunction

  task automatic zero_mem();
    for (int i = 0; i < 16; i++) mem[i] = 19'h0;
  endtask

  // Advance one clock and update the reference model with the sampled inputs
  task automatic step();
    bit acc;
    @(posedge clk);
    acc = we && (sweep_left == 0) && (wi != 0);
    if (acc) mem[wi] = mask_model(int'(wi), wd);
    if (!rst_n) begin
      sweep_left = 15;
      drop_exp   = 1'b0;
      zero_mem();
    end else begin
      drop_exp = we && (sweep_left > 0) && (wi != 0);
      if (clear) begin
        sweep_left = 15;
        zero_mem();
      end else if (sweep_left > 0) begin
        sweep_left--;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    int cnt;
    rst_n = 1'b0; clear = 1'b0; we = 1'b0; wi = '0; wd = '0; ri1 = '0; ri2 = '0;
    step();
    @(negedge clk);
    total++;
    if (a_busy !== 1'b1 || a_drop !== 1'b0) begin
      bad++;
      $display("FAIL reset_state busy=%b drop=%b required busy=1 drop=0", a_busy, a_drop);
    end
    step();
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!a_busy) break;
      cnt++;
      step();
    end
    step();
    total++;
    if (cnt != 15) begin
      bad++;
      $display("FAIL reset_busy_len got=%0d required=15", cnt);
    end
    for (int i = 0; i < 16; i++) begin
      ri1 = 4'(i); ri2 = 4'(15 - i);
      @(negedge clk);
      total++;
      if (a_rd1 !== 19'h0 || b_rd2 !== 19'h0) begin
        bad++;
        $display("FAIL reset_zero idx=%0d got=%h/%h required=0", i, a_rd1, b_rd2);
      end
      step();
    end
  endtask

  task automatic test_width_mask();
    we = 1'b1; wi = 4'd3; wd = 19'h7FFFF;
    step();
    wi = 4'd8;
    step();
    we = 1'b0; ri1 = 4'd3; ri2 = 4'd8;
    @(negedge clk);
    total++;
    if (a_rd1 !== 19'h7FFFF) begin
      bad++;
      $display("FAIL width_wide got=%h required=7ffff", a_rd1);
    end
    total++;
    if (a_rd2 !== 19'h0FFFF) begin
      bad++;
      $display("FAIL width_narrow got=%h required=0ffff", a_rd2);
    end
    step();
  endtask

  task automatic test_bypass();
    logic [18:0] old;
    old = mem[5];
    we = 1'b1; wi = 4'd5; wd = 19'h12345; ri1 = 4'd5;
    @(negedge clk);
    total++;
    if (a_rd1 !== 19'h12345) begin
      bad++;
      $display("FAIL bypass_on got=%h required=12345", a_rd1);
    end
    total++;
    if (b_rd1 !== old) begin
      bad++;
      $display("FAIL bypass_off_same got=%h required=%h", b_rd1, old);
    end
    step();
    we = 1'b0;
    @(negedge clk);
    total++;
    if (b_rd1 !== 19'h12345) begin
      bad++;
      $display("FAIL bypass_off_next got=%h required=12345", b_rd1);
    end
    step();
  endtask

  task automatic test_zero_reg();
    we = 1'b1; wi = 4'd0; wd = 19'h00ABC; ri1 = 4'd0;
    @(negedge clk);
    total++;
    if (a_rd1 !== 19'h0) begin
      bad++;
      $display("FAIL zero_bypass got=%h required=0", a_rd1);
    end
    step();
    we = 1'b0;
    @(negedge clk);
    total++;
    if (a_rd1 !== 19'h0 || a_drop !== 1'b0) begin
      bad++;
      $display("FAIL zero_reg rd=%h drop=%b required rd=0 drop=0", a_rd1, a_drop);
    end
    step();
  endtask

  task automatic test_clear_mid();
    int cnt;
    int pulses;
    we = 1'b1; wi = 4'd9; wd = 19'h00055;
    step();
    we = 1'b0; ri1 = 4'd9;
    @(negedge clk);
    total++;
    if (a_rd1 !== 19'h00055) begin
      bad++;
      $display("FAIL clear_preload got=%h required=00055", a_rd1);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    cnt = 0; pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (a_drop) pulses++;
      if (!a_busy) break;
      cnt++;
      if (cnt == 1) begin
        we = 1'b1; wi = 4'd9; wd = 19'h00077;
      end else begin
        we = 1'b0;
      end
      step();
    end
    step();
    total++;
    if (cnt != 15) begin
      bad++;
      $display("FAIL clear_busy_len got=%0d required=15", cnt);
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL clear_drop_pulses got=%0d required=1", pulses);
    end
    @(negedge clk);
    total++;
    if (a_rd1 !== 19'h0) begin
      bad++;
      $display("FAIL clear_result got=%h required=0", a_rd1);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int cnt;
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int k = 0; k < 6; k++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!b_busy) break;
      cnt++;
      step();
    end
    step();
    total++;
    if (cnt != 15) begin
      bad++;
      $display("FAIL reset_mid_len got=%0d required=15", cnt);
    end
  endtask

  task automatic test_random();
    logic [18:0] e;
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      clear = ($urandom_range(0, 59) == 0);
      we    = 1'($urandom_range(0, 1));
      wi    = 4'($urandom_range(0, 15));
      wd    = 19'($urandom);
      ri1   = ($urandom_range(0, 2) == 0) ? wi : 4'($urandom_range(0, 15));
      ri2   = ($urandom_range(0, 2) == 0) ? wi : 4'($urandom_range(0, 15));
      @(negedge clk);
      e = exp_rd(int'(ri1), 1'b1);
      total++;
      if (a_rd1 !== e) begin
        bad++;
        $display("FAIL rand_a_rd1 n=%0d got=%h required=%h", n, a_rd1, e);
      end
      e = exp_rd(int'(ri2), 1'b1);
      total++;
      if (a_rd2 !== e) begin
        bad++;
        $display("FAIL rand_a_rd2 n=%0d got=%h required=%h", n, a_rd2, e);
      end
      e = exp_rd(int'(ri1), 1'b0);
      total++;
      if (b_rd1 !== e) begin
        bad++;
        $display("FAIL rand_b_rd1 n=%0d got=%h required=%h", n, b_rd1, e);
      end
      e = exp_rd(int'(ri2), 1'b0);
      total++;
      if (b_rd2 !== e) begin
        bad++;
        $display("FAIL rand_b_rd2 n=%0d got=%h required=%h", n, b_rd2, e);
      end
      total++;
      if (a_busy !== (sweep_left > 0) || b_busy !== (sweep_left > 0)) begin
        bad++;
        $display("FAIL rand_busy n=%0d got=%b/%b required=%b", n, a_busy, b_busy, sweep_left > 0);
      end
      total++;
      if (a_drop !== drop_exp || b_drop !== drop_exp) begin
        bad++;
        $display("FAIL rand_drop n=%0d got=%b/%b required=%b", n, a_drop, b_drop, drop_exp);
      end
      step();
    end
    rst_n = 1'b1; clear = 1'b0; we = 1'b0;
    step();
  endtask

  initial begin
    sweep_left = 15;
    drop_exp   = 1'b0;
    zero_mem();
    test_reset();
    test_width_mask();
    test_bypass();
    test_zero_reg();
    test_clear_mid();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
